// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Shared types and default geometry for the VGA pixel pipeline
//                (video_driver and frame_line_fetcher).
//  Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    // Default visible geometry, shared with video_driver
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;

    // One framebuffer word: 8 bits per colour channel
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Line-fetch sequencer states
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_PRIME0 = 3'd1,
        ST_PRIME1 = 3'd2,
        ST_IDLE   = 3'd3,
        ST_FETCH  = 3'd4
    } fetch_state_t;

    // True in every state that holds a read request on the memory port
    function automatic logic is_fetching(input fetch_state_t s);
        return (s == ST_PRIME0) || (s == ST_PRIME1) || (s == ST_FETCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_line_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_line_fetcher_if
//  Description : Word-addressed read-only memory port used by the line
//                fetcher (request/stall handshake plus read data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_line_fetcher_if #(
    parameter int ADDR_W = 19
);
    import video_pkg::*;

    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_waitrequest;
    rgb24_t            mem_readdata;

    // Fetcher side issues requests
    modport master (
        output mem_read,
        output mem_address,
        input  mem_waitrequest,
        input  mem_readdata
    );

    // Memory side answers them
    modport slave (
        input  mem_read,
        input  mem_address,
        output mem_waitrequest,
        output mem_readdata
    );

endinterface
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : line_ram
//  Description : One-line buffer, simple dual-port RAM with a single write
//                port and a registered read port (maps to block RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module line_ram
    import video_pkg::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire rgb24_t        i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output rgb24_t             o_rdata
);

    rgb24_t r_mem [DEPTH];
    rgb24_t r_rdata;

    // Write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port gives the one-cycle pixel latency
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/frame_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : frame_line_fetcher
//  Description : Fetches the framebuffer one line ahead of the beam into a
//                ping-pong pair of line buffers and returns the pixel colour
//                for the driver's current x/y coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_line_fetcher
    import video_pkg::*;
#(
    parameter int          WIDTH  = DEF_WIDTH,
    parameter int          HEIGHT = DEF_HEIGHT,
    parameter int          ADDR_W = 19,
    parameter int unsigned BASE   = 0
) (
    input  wire logic            PixelClock,
    input  wire logic            reset,
    input  wire logic [9:0]      x,
    input  wire logic [8:0]      y,
    output logic [7:0]           r,
    output logic [7:0]           g,
    output logic [7:0]           b,
    output logic                 busy,
    output logic                 underrun,
    frame_line_fetcher_if.master mem
);

    localparam int          c_CW       = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(WIDTH - 1);
    localparam logic [9:0]  c_WIDTH_X  = 10'(WIDTH);
    localparam logic [8:0]  c_HEIGHT_Y = 9'(HEIGHT);
    localparam logic [8:0]  c_LAST_Y   = 9'(HEIGHT - 1);

    fetch_state_t      r_state, w_state_nxt;
    logic [8:0]        r_line, w_line_nxt;
    logic [c_CW-1:0]   r_col, w_col_nxt;
    logic [8:0]        r_prev_y;
    logic              r_mem_read;
    logic [ADDR_W-1:0] r_mem_address;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_underrun, w_set_underrun;
    logic              r_primed, w_set_primed;
    logic              w_we;
    logic              w_trig, w_acc, w_last;
    logic [8:0]        w_nl;
    logic              r_pix_valid, r_pix_bank;
    rgb24_t            w_rd [2];
    rgb24_t            w_pix;
    logic [c_CW-1:0]   w_raddr;

    // Any change of y announces a new line; prefetch the one after it
    assign w_trig = (y != r_prev_y);
    assign w_nl   = (y == c_LAST_Y) ? 9'd0 : (y + 9'd1);
    assign w_acc  = r_mem_read & ~mem.mem_waitrequest;
    assign w_last = (r_col == c_LAST_COL);

    // Next-state, counter and write-enable decode for the fetch sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_line_nxt     = r_line;
        w_col_nxt      = r_col;
        w_we           = 1'b0;
        w_set_underrun = 1'b0;
        w_set_primed   = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_PRIME0;
                w_line_nxt  = 9'd0;
                w_col_nxt   = '0;
            end
            // Priming ignores y changes: both buffers must be filled first
            ST_PRIME0, ST_PRIME1: begin
                if (w_acc) begin
                    w_we = 1'b1;
                    if (w_last) begin
                        w_col_nxt = '0;
                        if (r_state == ST_PRIME0) begin
                            w_state_nxt = ST_PRIME1;
                            w_line_nxt  = 9'd1;
                        end else begin
                            w_state_nxt  = ST_IDLE;
                            w_set_primed = 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = ST_FETCH;
                    w_line_nxt  = w_nl;
                    w_col_nxt   = '0;
                end
            end
            ST_FETCH: begin
                if (w_acc && w_last) begin
                    // Final column lands; a coincident trigger is not an underrun
                    w_we      = 1'b1;
                    w_col_nxt = '0;
                    if (w_trig) begin
                        w_line_nxt = w_nl;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_trig) begin
                    // Beam overtook the fetch: drop it without writing, restart
                    w_line_nxt     = w_nl;
                    w_col_nxt      = '0;
                    w_set_underrun = 1'b1;
                end else if (w_acc) begin
                    w_we      = 1'b1;
                    w_col_nxt = r_col + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    // Request address for the next cycle, wrapping modulo 2^ADDR_W
    assign w_addr_nxt = ADDR_W'(BASE) + ADDR_W'(w_line_nxt) * ADDR_W'(WIDTH)
                      + ADDR_W'(w_col_nxt);

    // Sequencer state, counters and registered memory request
    always_ff @(posedge PixelClock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_RESET;
            r_line        <= 9'd0;
            r_col         <= '0;
            r_prev_y      <= 9'd0;
            r_mem_read    <= 1'b0;
            r_mem_address <= '0;
            r_underrun    <= 1'b0;
            r_primed      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_line        <= w_line_nxt;
            r_col         <= w_col_nxt;
            r_prev_y      <= y;
            r_mem_read    <= is_fetching(w_state_nxt);
            r_mem_address <= w_addr_nxt;
            r_underrun    <= r_underrun | w_set_underrun;
            r_primed      <= r_primed | w_set_primed;
        end
    end

    assign mem.mem_read    = r_mem_read;
    assign mem.mem_address = r_mem_address;
    assign busy            = is_fetching(r_state);
    assign underrun        = r_underrun;

    // Both banks are read at column x; the bank for the line is chosen later
    assign w_raddr = c_CW'(x);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        line_ram #(
            .DEPTH (WIDTH)
        ) u_line_ram (
            .clk     (PixelClock),
            .i_we    (w_we && (r_line[0] == 1'(gi))),
            .i_waddr (r_col),
            .i_wdata (mem.mem_readdata),
            .i_raddr (w_raddr),
            .o_rdata (w_rd[gi])
        );
    end

    // Visibility and bank select, aligned with the RAM read register
    always_ff @(posedge PixelClock or posedge reset) begin
        if (reset) begin
            r_pix_valid <= 1'b0;
            r_pix_bank  <= 1'b0;
        end else begin
            r_pix_valid <= (x < c_WIDTH_X) && (y < c_HEIGHT_Y) && r_primed;
            r_pix_bank  <= y[0];
        end
    end

    assign w_pix = r_pix_valid ? w_rd[r_pix_bank] : '0;
    assign r     = w_pix.r;
    assign g     = w_pix.g;
    assign b     = w_pix.b;

endmodule
`default_nettype wire

// File: tb/tb_frame_line_fetcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_line_fetcher
//  Description : Directed self-checking bench for frame_line_fetcher against
//                a pattern memory whose word at address A holds A.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_line_fetcher;
    import video_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] r, g, b;
    logic       busy, underrun;
    logic       stall_en = 1'b0;
    int         cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    frame_line_fetcher_if #(.ADDR_W(19)) mif ();

    frame_line_fetcher #(
        .WIDTH  (640),
        .HEIGHT (480),
        .ADDR_W (19),
        .BASE   (0)
    ) dut (
        .PixelClock (clk),
        .reset      (rst),
        .x          (x),
        .y          (y),
        .r          (r),
        .g          (g),
        .b          (b),
        .busy       (busy),
        .underrun   (underrun),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    // Pattern memory: data equals address; stalls on odd cycles when enabled
    always @(posedge clk) cyc <= cyc + 1;
    assign mif.mem_waitrequest = stall_en & cyc[0];
    assign mif.mem_readdata    = rgb24_t'({5'd0, mif.mem_address});

    // Accepted-address log and stall-hold monitor
    logic [31:0] q_acc[$];
    int          hold_err = 0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_addr = '0;
    always @(posedge clk) begin
        if (mif.mem_read && !mif.mem_waitrequest) q_acc.push_back(32'(mif.mem_address));
        if (prev_stall && mif.mem_read && (mif.mem_address != prev_addr)) hold_err <= hold_err + 1;
        prev_stall <= mif.mem_read && mif.mem_waitrequest;
        prev_addr  <= mif.mem_address;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait until busy has been seen high and then falls; returns high cycles
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    // Index of the first logged address breaking first_addr+i, or -1
    task automatic seq_check(input string tag, input int start, input int n, input int first_addr);
        int bad;
        bad = -1;
        for (int i = 0; i < n; i++) begin
            if (start + i >= q_acc.size()) begin
                if (bad < 0) bad = i;
            end else if (q_acc[start + i] != 32'(first_addr + i)) begin
                if (bad < 0) bad = i;
            end
        end
        check_eq(tag, 32'(bad), 32'hFFFF_FFFF);
    endtask

    // Present one line plus 8 blanking columns; count wrong pixels
    task automatic sweep_line(input int yy, output int errs);
        logic [23:0] exp;
        errs = 0;
        for (int xx = 0; xx < 648; xx++) begin
            x = 10'(xx);
            y = 9'(yy);
            step();
            exp = (xx < 640) ? 24'(yy * 640 + xx) : 24'd0;
            if ({r, g, b} !== exp) errs++;
        end
    endtask

    initial begin
        int cnt, nz, errs, qs, hb;

        // ---------------- reset state ----------------
        rst = 1'b1;
        x   = 10'd5;
        y   = 9'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset rgb", {8'd0, r, g, b}, 32'd0);
        check_eq("reset mem_read", 32'(mif.mem_read), 32'd0);
        check_eq("reset mem_address", 32'(mif.mem_address), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset underrun", 32'(underrun), 32'd0);

        // ---------------- priming ----------------
        @(negedge clk);
        rst = 1'b0;
        qs  = q_acc.size();
        cnt = 0;
        nz  = 0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (busy) begin
                cnt++;
                if ({r, g, b} != 24'd0) nz++;
            end else if (cnt > 0) break;
        end
        check_eq("prime busy cycles", 32'(cnt), 32'd1280);
        check_eq("prime rgb nonzero", 32'(nz), 32'd0);
        check_eq("prime accepts", 32'(q_acc.size() - qs), 32'd1280);
        seq_check("prime addr seq", qs, 1280, 0);
        step();
        check_eq("primed pixel (5,0)", {8'd0, r, g, b}, 32'd5);

        // ---------------- driver sweep, lines 0..7 ----------------
        nz = 0;
        for (int yy = 0; yy < 8; yy++) begin
            sweep_line(yy, errs);
            nz += errs;
        end
        check_eq("sweep 0..7 pixel errs", 32'(nz), 32'd0);
        check_eq("sweep underrun", 32'(underrun), 32'd0);

        // ---------------- wrap 479 -> 0 ----------------
        x = 10'd640;
        y = 9'd478;
        repeat (648) step();
        sweep_line(479, errs);
        check_eq("line 479 pixel errs", 32'(errs), 32'd0);
        qs = q_acc.size();
        sweep_line(0, errs);
        check_eq("line 0 after wrap errs", 32'(errs), 32'd0);
        check_eq("wrap accepts", 32'(q_acc.size() - qs), 32'd640);
        seq_check("wrap addr seq 640..", qs, 640, 640);
        check_eq("wrap underrun", 32'(underrun), 32'd0);

        // ---------------- stalled fetch ----------------
        stall_en = 1'b1;
        x = 10'd640;
        if (cyc[0]) step();
        hb = hold_err;
        qs = q_acc.size();
        y  = 9'd1;
        count_busy(cnt);
        check_eq("stall busy cycles", 32'(cnt), 32'd1280);
        check_eq("stall accepts", 32'(q_acc.size() - qs), 32'd640);
        seq_check("stall addr seq 1280..", qs, 640, 1280);
        check_eq("stall addr hold", 32'(hold_err - hb), 32'd0);
        stall_en = 1'b0;
        sweep_line(2, errs);
        check_eq("line 2 after stall errs", 32'(errs), 32'd0);

        // ---------------- last accept coincides with trigger ----------------
        qs = q_acc.size();
        x  = 10'd640;
        y  = 9'd5;
        repeat (640) step();
        y = 9'd6;
        step();
        check_eq("coincide underrun", 32'(underrun), 32'd0);
        check_eq("coincide mem_read", 32'(mif.mem_read), 32'd1);
        check_eq("coincide restart addr", 32'(mif.mem_address), 32'd4480);
        count_busy(cnt);
        check_eq("coincide accepts", 32'(q_acc.size() - qs), 32'd1280);
        seq_check("coincide addr seq 3840..", qs, 1280, 3840);

        // ---------------- underrun ----------------
        stall_en = 1'b1;
        qs = q_acc.size();
        y  = 9'd3;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (q_acc.size() - qs >= 300) break;
        end
        check_eq("300 accepts reached", 32'(q_acc.size() - qs >= 300), 32'd1);
        y = 9'd4;
        step();
        check_eq("underrun set", 32'(underrun), 32'd1);
        check_eq("underrun restart addr", 32'(mif.mem_address), 32'd3200);
        check_eq("underrun restart read", 32'(mif.mem_read), 32'd1);
        check_eq("accepts before abandon", 32'(q_acc.size() - qs), 32'd300);
        seq_check("abandoned addr seq 2560..", qs, 300, 2560);
        count_busy(cnt);
        check_eq("underrun sticky", 32'(underrun), 32'd1);
        stall_en = 1'b0;

        // ---------------- out-of-range coordinates ----------------
        x = 10'd700;
        y = 9'd4;
        step();
        check_eq("x=700 black", {8'd0, r, g, b}, 32'd0);
        x = 10'd5;
        y = 9'd500;
        step();
        check_eq("y=500 black", {8'd0, r, g, b}, 32'd0);
        x = 10'd639;
        y = 9'd5;
        step();
        check_eq("pixel (639,5)", {8'd0, r, g, b}, 32'd3839);

        // ---------------- reset mid-fetch ----------------
        y = 9'd10;
        repeat (20) step();
        check_eq("mid-fetch busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("async reset mem_read", 32'(mif.mem_read), 32'd0);
        check_eq("async reset busy", 32'(busy), 32'd0);
        check_eq("async reset underrun", 32'(underrun), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        qs = q_acc.size();
        count_busy(cnt);
        check_eq("reprime busy cycles", 32'(cnt), 32'd1280);
        seq_check("reprime addr seq 0..", qs, 1280, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
